// File: rtl/cart_bus_pkg.sv
// cart_bus_pkg: shared types and constants for the cartridge bus arbiter.
// Optional feature macro: CART_ARB_RR_EN (round-robin arbitration, see cart_arb_sel).
package cart_bus_pkg;

  // Bus sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } cart_state_e;

  // Requester port indices
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // External RAM window decoded on A[15:13]
  localparam logic [2:0] CS_HI = 3'b101;

  // External RAM chip-select decode for a latched address
  function automatic logic cs_decode(input logic [15:0] addr);
    return (addr[15:13] == CS_HI);
  endfunction

endpackage

// File: rtl/cart_arb_sel.sv
// cart_arb_sel: combinational grant selection between core and debug ports.
// Macro CART_ARB_RR_EN selects round-robin on conflicts; otherwise the core wins.
module cart_arb_sel
  import cart_bus_pkg::*;
(
  input  logic c_elig_i,
  input  logic d_elig_i,
  input  logic rr_last_i,
  output logic gnt_valid_o,
  output logic gnt_port_o
);

`ifndef CART_ARB_RR_EN
  // rr_last is meaningless under fixed priority; keep it visibly unused
  logic unused_rr_s;
  assign unused_rr_s = rr_last_i;
`endif

  // Pick the winning port; a lone requester always wins
  always_comb begin
    gnt_valid_o = c_elig_i | d_elig_i;
    gnt_port_o  = PORT_CORE;
    if (c_elig_i && d_elig_i) begin
`ifdef CART_ARB_RR_EN
      gnt_port_o = (rr_last_i == PORT_CORE) ? PORT_DBG : PORT_CORE;
`else
      gnt_port_o = PORT_CORE;
`endif
    end else if (d_elig_i) begin
      gnt_port_o = PORT_DBG;
    end else begin
      gnt_port_o = PORT_CORE;
    end
  end

endmodule

// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter: shares the cartridge bus between the Game Boy core (port 0)
// and the UART debug engine (port 1); each access runs SETUP -> STROBE -> HOLD.
// Macro CART_ARB_RR_EN enables round-robin conflict resolution (default: core priority).
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [7:0]  c_wdata,
  output logic        c_ack,
  output logic [7:0]  c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        bus_cs,
  output logic        busy
);

  // Counter reload values: each phase lasts *_CYC cycles counting down to zero
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  cart_state_e state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic        we_q;
  logic [7:0]  rd_buf_q;
  logic [15:0] bus_a_q;
  logic [7:0]  bus_dout_q;
  logic        bus_oe_q, bus_rd_q, bus_wr_q, bus_cs_q, busy_q;
  logic        c_ack_q, d_ack_q;
  logic [7:0]  c_rdata_q, d_rdata_q;

  logic        c_elig_s, d_elig_s, gnt_valid_s, gnt_port_s, rr_last_s;
  logic        sel_we_s;
  logic [15:0] sel_addr_s;
  logic [7:0]  sel_wdata_s;

  // The core is eligible only while not halted; halt is only looked at in IDLE
  assign c_elig_s = c_req & ~halt;
  assign d_elig_s = d_req;

  cart_arb_sel u_sel (
    .c_elig_i    (c_elig_s),
    .d_elig_i    (d_elig_s),
    .rr_last_i   (rr_last_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_port_o  (gnt_port_s)
  );

  // Route the winning port's request fields toward the latch registers
  always_comb begin
    if (gnt_port_s == PORT_DBG) begin
      sel_we_s    = d_we;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
    end else begin
      sel_we_s    = c_we;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
    end
  end

`ifdef CART_ARB_RR_EN
  logic rr_last_q;
  // Remember the last granted port for round-robin conflict resolution
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_q <= PORT_DBG;
    end else if (state_q == ST_IDLE && gnt_valid_s) begin
      rr_last_q <= gnt_port_s;
    end else begin
      rr_last_q <= rr_last_q;
    end
  end
  assign rr_last_s = rr_last_q;
`else
  assign rr_last_s = PORT_DBG;
`endif

  // Access sequencer with registered bus outputs, acks and read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= PORT_CORE;
      we_q       <= 1'b0;
      rd_buf_q   <= 8'h00;
      bus_a_q    <= 16'h0000;
      bus_dout_q <= 8'h00;
      bus_oe_q   <= 1'b0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      bus_cs_q   <= 1'b0;
      busy_q     <= 1'b0;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      c_rdata_q  <= 8'h00;
      d_rdata_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (gnt_valid_s) begin
            owner_q    <= gnt_port_s;
            we_q       <= sel_we_s;
            bus_a_q    <= sel_addr_s;
            bus_cs_q   <= cs_decode(sel_addr_s);
            bus_oe_q   <= sel_we_s;
            bus_dout_q <= sel_wdata_s;
            busy_q     <= 1'b1;
            cnt_q      <= SETUP_LD;
            state_q    <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 4'd0) begin
            bus_rd_q <= ~we_q;
            bus_wr_q <= we_q;
            cnt_q    <= STROBE_LD;
            state_q  <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 4'd0) begin
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            rd_buf_q <= bus_din;
            cnt_q    <= HOLD_LD;
            state_q  <= ST_HOLD;
            // Single-cycle HOLD: the ack cycle starts right now, so use bus_din directly
            if (HOLD_LD == 4'd0) begin
              if (owner_q == PORT_DBG) begin
                d_ack_q <= 1'b1;
                if (!we_q) d_rdata_q <= bus_din;
              end else begin
                c_ack_q <= 1'b1;
                if (!we_q) c_rdata_q <= bus_din;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 4'd0) begin
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_a_q    <= 16'h0000;
            bus_dout_q <= 8'h00;
            bus_oe_q   <= 1'b0;
            bus_cs_q   <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            // Entering the last HOLD cycle: raise the owner's ack with captured data
            if (cnt_q == 4'd1) begin
              if (owner_q == PORT_DBG) begin
                d_ack_q <= 1'b1;
                if (!we_q) d_rdata_q <= rd_buf_q;
              end else begin
                c_ack_q <= 1'b1;
                if (!we_q) c_rdata_q <= rd_buf_q;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_a    = bus_a_q;
  assign bus_dout = bus_dout_q;
  assign bus_oe   = bus_oe_q;
  assign bus_rd   = bus_rd_q;
  assign bus_wr   = bus_wr_q;
  assign bus_cs   = bus_cs_q;
  assign busy     = busy_q;
  assign c_ack    = c_ack_q;
  assign d_ack    = d_ack_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// tb_cart_bus_arbiter: directed self-checking bench for cart_bus_arbiter.
// Expected arbitration order depends on CART_ARB_RR_EN.
module tb_cart_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] c_addr = 16'h0000, d_addr = 16'h0000;
  logic [7:0]  c_wdata = 8'h00, d_wdata = 8'h00, bus_din = 8'h00;
  logic        c_ack, d_ack, bus_oe, bus_rd, bus_wr, bus_cs, busy;
  logic [7:0]  c_rdata, d_rdata, bus_dout;
  logic [15:0] bus_a;

  // second instance with long timing
  logic        c2_req = 1'b0, c2_we = 1'b0;
  logic [15:0] c2_addr = 16'h0000;
  logic [7:0]  c2_wdata = 8'h00;
  logic        c2_ack, d2_ack, bus2_oe, bus2_rd, bus2_wr, bus2_cs, busy2;
  logic [7:0]  c2_rdata, d2_rdata, bus2_dout;
  logic [15:0] bus2_a;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cart_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_cs(bus_cs), .busy(busy)
  );

  cart_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .halt(1'b0),
    .c_req(c2_req), .c_we(c2_we), .c_addr(c2_addr), .c_wdata(c2_wdata),
    .c_ack(c2_ack), .c_rdata(c2_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(8'h00),
    .d_ack(d2_ack), .d_rdata(d2_rdata),
    .bus_a(bus2_a), .bus_dout(bus2_dout), .bus_oe(bus2_oe), .bus_din(bus_din),
    .bus_rd(bus2_rd), .bus_wr(bus2_wr), .bus_cs(bus2_cs), .busy(busy2)
  );

  // Drive one access from the current negedge and record what the bus did until ack
  task automatic access(input bit dbg, input bit we, input logic [15:0] addr,
                        input logic [7:0] wd, output int ack_at, output int n_rd,
                        output int n_wr, output int n_cs, output int n_oe,
                        output int n_dout, output int n_addr, output int n_other);
    ack_at = -1; n_rd = 0; n_wr = 0; n_cs = 0; n_oe = 0; n_dout = 0; n_addr = 0; n_other = 0;
    if (dbg) begin
      d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    end else begin
      c_we = we; c_addr = addr; c_wdata = wd; c_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_rd) n_rd++;
      if (bus_wr) n_wr++;
      if (bus_cs) n_cs++;
      if (bus_oe) n_oe++;
      if (bus_oe && bus_dout == wd) n_dout++;
      if (busy && bus_a == addr) n_addr++;
      if (dbg ? c_ack : d_ack) n_other++;
      if (dbg ? d_ack : c_ack) begin
        ack_at = i;
        break;
      end
    end
    if (dbg) d_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [46:0] outs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, busy, c_ack, d_ack, c_rdata, d_rdata};
    n_checks++;
    if (outs !== 47'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_core_read();
    int a, r, w, cs, oe, dd, ad, ot;
    bus_din = 8'h5A;
    access(1'b0, 1'b0, 16'h4000, 8'h00, a, r, w, cs, oe, dd, ad, ot);
    n_checks++;
    if (a !== 4) $display("FAIL rd_ack_latency: got %0d expected 4", a); else n_pass++;
    n_checks++;
    if (r !== 2) $display("FAIL rd_strobe_width: got %0d expected 2", r); else n_pass++;
    n_checks++;
    if (c_rdata !== 8'h5A) $display("FAIL rd_data: got %h expected 5a", c_rdata); else n_pass++;
    n_checks++;
    if (cs !== 0 || w !== 0 || oe !== 0) $display("FAIL rd_cs_wr_oe: got cs=%0d wr=%0d oe=%0d expected 0 0 0", cs, w, oe);
    else n_pass++;
    n_checks++;
    if (ad !== 4) $display("FAIL rd_addr_stable: got %0d expected 4", ad); else n_pass++;
    bus_din = 8'hEE;
    @(negedge clk);
    n_checks++;
    if (c_ack !== 1'b0 || busy !== 1'b0 || c_rdata !== 8'h5A)
      $display("FAIL rd_after_ack: got ack=%b busy=%b rdata=%h expected 0 0 5a", c_ack, busy, c_rdata);
    else n_pass++;
  endtask

  task automatic test_dbg_write();
    int a, r, w, cs, oe, dd, ad, ot;
    access(1'b1, 1'b1, 16'hA123, 8'h3C, a, r, w, cs, oe, dd, ad, ot);
    n_checks++;
    if (cs !== 4 || oe !== 4 || dd !== 4)
      $display("FAIL wr_cs_oe_dout: got cs=%0d oe=%0d dout=%0d expected 4 4 4", cs, oe, dd);
    else n_pass++;
    n_checks++;
    if (w !== 2 || r !== 0) $display("FAIL wr_strobe: got wr=%0d rd=%0d expected 2 0", w, r); else n_pass++;
    n_checks++;
    if (a !== 4 || ot !== 0) $display("FAIL wr_ack: got at=%0d other=%0d expected 4 0", a, ot); else n_pass++;
    n_checks++;
    if (d_rdata !== 8'h00) $display("FAIL wr_rdata_kept: got %h expected 00", d_rdata); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (d_ack !== 1'b0) $display("FAIL wr_ack_pulse: got %b expected 0", d_ack); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [3:0] exp_win;
    int winner, lat;
`ifdef CART_ARB_RR_EN
    exp_win = 4'b1010;
`else
    exp_win = 4'b0000;
`endif
    bus_din = 8'h21;
    for (int k = 0; k < 4; k++) begin
      c_we = 1'b0; d_we = 1'b0; c_addr = 16'h1000; d_addr = 16'h2000;
      c_req = 1'b1; d_req = 1'b1;
      winner = -1; lat = -1;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if (c_ack) begin winner = 0; lat = i; break; end
        if (d_ack) begin winner = 1; lat = i; break; end
      end
      c_req = 1'b0; d_req = 1'b0;
      n_checks++;
      if (winner !== int'(exp_win[k]) || lat !== 4)
        $display("FAIL conflict_%0d: got winner=%0d lat=%0d expected %0d 4", k, winner, lat, exp_win[k]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    int a, r, w, cs, oe, dd, ad, ot;
    int seen;
    halt = 1'b1;
    c_we = 1'b0; c_addr = 16'h0100; c_req = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_ack || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL halt_blocks_core: got %0d active cycles expected 0", seen); else n_pass++;
    access(1'b1, 1'b1, 16'h0200, 8'h44, a, r, w, cs, oe, dd, ad, ot);
    n_checks++;
    if (a !== 4 || ot !== 0) $display("FAIL halt_dbg_served: got at=%0d c_acks=%0d expected 4 0", a, ot); else n_pass++;
    halt = 1'b0;
    bus_din = 8'h66;
    access(1'b0, 1'b0, 16'h0100, 8'h00, a, r, w, cs, oe, dd, ad, ot);
    n_checks++;
    if (a !== 5 || c_rdata !== 8'h66)
      $display("FAIL unhalt_core_grant: got at=%0d rdata=%h expected 5 66", a, c_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [46:0] outs;
    int a, r, w, cs, oe, dd, ad, ot;
    bus_din = 8'h77;
    c_we = 1'b0; c_addr = 16'hB000; c_req = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_rd !== 1'b1 || bus_cs !== 1'b1)
      $display("FAIL midrst_in_strobe: got rd=%b cs=%b expected 1 1", bus_rd, bus_cs);
    else n_pass++;
    rst_n = 1'b0; c_req = 1'b0;
    @(negedge clk);
    outs = {bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, busy, c_ack, d_ack, c_rdata, d_rdata};
    n_checks++;
    if (outs !== 47'd0) $display("FAIL midrst_outputs: got %h expected 0", outs); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (c_ack !== 1'b0) $display("FAIL midrst_no_ack: got %b expected 0", c_ack); else n_pass++;
    bus_din = 8'h11;
    access(1'b0, 1'b0, 16'h4001, 8'h00, a, r, w, cs, oe, dd, ad, ot);
    n_checks++;
    if (a !== 4 || c_rdata !== 8'h11)
      $display("FAIL midrst_recover: got at=%0d rdata=%h expected 4 11", a, c_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_long_timing();
    int a, w, ad;
    a = -1; w = 0; ad = 0;
    c2_we = 1'b1; c2_addr = 16'h2345; c2_wdata = 8'h99; c2_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus2_wr) w++;
      if (busy2 && bus2_a == 16'h2345) ad++;
      if (c2_ack) begin a = i; break; end
    end
    c2_req = 1'b0;
    n_checks++;
    if (w !== 5) $display("FAIL long_strobe: got %0d expected 5", w); else n_pass++;
    n_checks++;
    if (a !== 10) $display("FAIL long_ack_latency: got %0d expected 10", a); else n_pass++;
    n_checks++;
    if (ad !== 10) $display("FAIL long_addr_stable: got %0d expected 10", ad); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (c2_ack !== 1'b0 || busy2 !== 1'b0)
      $display("FAIL long_end: got ack=%b busy=%b expected 0 0", c2_ack, busy2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dbg_write();
    test_conflict();
    test_halt();
    test_reset_mid();
    test_long_timing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
